// File: rtl/letter_pkg.sv
// Shared constants for the letter datapath: letter code width, default
// buffer depth and the occupancy-counter width helper.
package letter_pkg;

    localparam int LETTER_WIDTH     = 5;
    localparam int LETTER_BUF_DEPTH = 1000;

    // Bits needed to hold an occupancy value in the range 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port block RAM, read-first on both ports.
// LOW_LATENCY gives one cycle of read latency, otherwise an extra output register.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "LOW_LATENCY"
) (
    input  logic                         clka,
    input  logic                         ena,
    input  logic                         wea,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    output logic [RAM_WIDTH-1:0]         douta,
    input  logic                         enb,
    input  logic                         web,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dinb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a;
    logic [RAM_WIDTH-1:0] ram_data_b;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) ram[addra] <= dina;
            ram_data_a <= ram[addra];
        end
        if (enb) begin
            if (web) ram[addrb] <= dinb;
            ram_data_b <= ram[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
            assign douta = ram_data_a;
            assign doutb = ram_data_b;
        end else begin : g_out_reg
            logic [RAM_WIDTH-1:0] douta_reg;
            logic [RAM_WIDTH-1:0] doutb_reg;
            always_ff @(posedge clka) begin
                douta_reg <= ram_data_a;
                doutb_reg <= ram_data_b;
            end
            assign douta = douta_reg;
            assign doutb = doutb_reg;
        end
    endgenerate

endmodule

// File: rtl/letter_stream_fifo.sv
// Letter FIFO: block-RAM storage plus a two-entry output stage (head + prefetch)
// so the head falls through to the consumer, with valid/ready on both sides.
module letter_stream_fifo
    import letter_pkg::*;
#(
    parameter int WIDTH       = LETTER_WIDTH,
    parameter int DEPTH       = LETTER_BUF_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          flush_in,
    input  logic                          wr_valid_in,
    input  logic [WIDTH-1:0]              wr_data_in,
    output logic                          wr_ready_out,
    output logic                          rd_valid_out,
    output logic [WIDTH-1:0]              rd_data_out,
    input  logic                          rd_ready_in,
    output logic [count_width(DEPTH)-1:0] count_out,
    output logic                          almost_full_out,
    output logic                          overflow_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    ram_cnt_reg;
    logic             inflight_reg;
    logic             head_valid_reg;
    logic             pre_valid_reg;
    logic [WIDTH-1:0] head_data_reg;
    logic [WIDTH-1:0] pre_data_reg;
    logic             overflow_reg;

    logic [WIDTH-1:0] ram_dout;
    logic [WIDTH-1:0] unused_douta;
    logic             wr_accept;
    logic             pop;
    logic             issue;
    logic [1:0]       pipe_cnt;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_ready_out    = count_reg < CW'(DEPTH);
    assign almost_full_out = count_reg >= CW'(AFULL_LEVEL);
    assign count_out       = count_reg;
    assign rd_valid_out    = head_valid_reg;
    assign rd_data_out     = head_data_reg;
    assign overflow_out    = overflow_reg;

    assign wr_accept = wr_valid_in && wr_ready_out;
    assign pop       = head_valid_reg && rd_ready_in;

    // Head, prefetch and the read in flight never exceed two entries, so a
    // read is issued only when its data is guaranteed a slot on arrival.
    assign pipe_cnt = 2'(head_valid_reg) + 2'(pre_valid_reg) + 2'(inflight_reg);
    assign issue    = (ram_cnt_reg != '0) && ((pipe_cnt - 2'(pop)) <= 2'd1);

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ram_cnt_reg    <= '0;
            inflight_reg   <= 1'b0;
            head_valid_reg <= 1'b0;
            pre_valid_reg  <= 1'b0;
            head_data_reg  <= '0;
            pre_data_reg   <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (issue)     rd_ptr_reg <= next_ptr(rd_ptr_reg);
            if (wr_valid_in && !wr_ready_out) overflow_reg <= 1'b1;
            count_reg    <= count_reg + CW'(wr_accept) - CW'(pop);
            ram_cnt_reg  <= ram_cnt_reg + CW'(wr_accept) - CW'(issue);
            inflight_reg <= issue;

            if (pop || !head_valid_reg) begin
                if (pre_valid_reg) begin
                    head_data_reg  <= pre_data_reg;
                    head_valid_reg <= 1'b1;
                    pre_valid_reg  <= inflight_reg;
                    if (inflight_reg) pre_data_reg <= ram_dout;
                end else if (inflight_reg) begin
                    head_data_reg  <= ram_dout;
                    head_valid_reg <= 1'b1;
                end else begin
                    head_valid_reg <= 1'b0;
                end
            end else if (inflight_reg) begin
                pre_data_reg  <= ram_dout;
                pre_valid_reg <= 1'b1;
            end
        end
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (WIDTH),
        .RAM_DEPTH       (DEPTH),
        .RAM_PERFORMANCE ("LOW_LATENCY")
    ) u_ram (
        .clka  (clk_in),
        .ena   (wr_accept),
        .wea   (wr_accept),
        .addra (wr_ptr_reg),
        .dina  (wr_data_in),
        .douta (unused_douta),
        .enb   (issue),
        .web   (1'b0),
        .addrb (rd_ptr_reg),
        .dinb  ('0),
        .doutb (ram_dout)
    );

endmodule

// File: tb/tb_letter_stream_fifo.sv
// Bench for letter_stream_fifo: directed scenarios then randomized traffic, all
// checked every cycle against a queue model where each entry is visible two edges after its write.
module tb_letter_stream_fifo;
    import letter_pkg::*;

    localparam int WIDTH = LETTER_WIDTH;
    localparam int DEPTH = 7;
    localparam int AFULL = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             flush_in = 1'b0;
    logic             wr_valid_in = 1'b0;
    logic [WIDTH-1:0] wr_data_in = '0;
    logic             wr_ready_out;
    logic             rd_valid_out;
    logic [WIDTH-1:0] rd_data_out;
    logic             rd_ready_in = 1'b0;
    logic [CW-1:0]    count_out;
    logic             almost_full_out;
    logic             overflow_out;

    always #5 clk_in = ~clk_in;

    letter_stream_fifo #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .flush_in        (flush_in),
        .wr_valid_in     (wr_valid_in),
        .wr_data_in      (wr_data_in),
        .wr_ready_out    (wr_ready_out),
        .rd_valid_out    (rd_valid_out),
        .rd_data_out     (rd_data_out),
        .rd_ready_in     (rd_ready_in),
        .count_out       (count_out),
        .almost_full_out (almost_full_out),
        .overflow_out    (overflow_out)
    );

    typedef struct {
        int data;
        int wedge;
    } entry_t;

    entry_t model_q[$];
    int     model_ovf = 0;
    int     edge_n = 0;
    bit     after_rst = 1'b0;
    bit     armed = 1'b0;
    int     vectors = 0;
    int     miscompares = 0;
    int     pops = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit model_valid();
        return (model_q.size() > 0) && (model_q[0].wedge + 2 <= edge_n);
    endfunction

    task automatic check_outputs();
        bit v;
        v = model_valid();
        check_eq("rd_valid", int'(rd_valid_out), int'(v));
        if (v) check_eq("rd_data", int'(rd_data_out), model_q[0].data);
        if (after_rst) check_eq("rd_data_reset", int'(rd_data_out), 0);
        check_eq("count", int'(count_out), model_q.size());
        check_eq("wr_ready", int'(wr_ready_out), int'(model_q.size() < DEPTH));
        check_eq("almost_full", int'(almost_full_out), int'(model_q.size() >= AFULL));
        check_eq("overflow", int'(overflow_out), model_ovf);
    endtask

    // One clock: check the state left by the previous edge, drive the next
    // inputs and advance the model across the coming edge.
    task automatic step(input bit rst, input bit flush, input bit wv, input int wd, input bit rr);
        bit     pop;
        bit     acc;
        entry_t e;
        @(negedge clk_in);
        if (armed) check_outputs();
        rst_in      = rst;
        flush_in    = flush;
        wr_valid_in = wv;
        wr_data_in  = WIDTH'(wd);
        rd_ready_in = rr;
        pop = model_valid() && rr;
        acc = wv && (model_q.size() < DEPTH);
        edge_n++;
        if (rst || flush) begin
            model_q.delete();
            model_ovf = 0;
        end else begin
            if (wv && !acc) model_ovf = 1;
            if (pop) begin
                $display("pop %0d: data %0d (model %0d)", pops, rd_data_out, model_q[0].data);
                pops++;
                void'(model_q.pop_front());
            end
            if (acc) begin
                e.data  = wd % (1 << WIDTH);
                e.wedge = edge_n;
                model_q.push_back(e);
            end
        end
        after_rst = rst;
        if (rst) armed = 1'b1;
    endtask

    initial begin
        int wr_pct;
        int rd_pct;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // 'A' into an empty FIFO with the consumer stalled, then drain it
        step(0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1);

        // fill to capacity, one refused write, then drain in order
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, i, 0);
        step(0, 0, 1, 9, 1);
        repeat (DEPTH + 3) step(0, 0, 0, 0, 1);

        // continuous stream with the consumer always ready
        for (int i = 0; i < 20; i++) step(0, 0, 1, i, 1);
        repeat (6) step(0, 0, 0, 0, 1);

        // flush at occupancy 4 with a write and a pop presented alongside
        for (int i = 0; i < 4; i++) step(0, 0, 1, 10 + i, 0);
        step(0, 1, 1, 31, 1);
        step(0, 0, 1, 17, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1);

        // reset mid-stream at occupancy 6, then behave as from power-up
        for (int i = 0; i < 6; i++) step(0, 0, 1, 20 + i, 0);
        step(1, 0, 1, 5, 1);
        step(0, 0, 1, 3, 0);
        step(0, 0, 1, 4, 0);
        repeat (3) step(0, 0, 0, 0, 1);

        // randomized traffic in bursts of varying write/read pressure
        for (int blk = 0; blk < 15; blk++) begin
            wr_pct = 25 * $urandom_range(1, 4);
            rd_pct = 25 * $urandom_range(1, 4);
            for (int n = 0; n < 200; n++) begin
                step($urandom_range(0, 399) == 0,
                     $urandom_range(0, 99) == 0,
                     $urandom_range(1, 100) <= wr_pct,
                     $urandom_range(0, 31),
                     $urandom_range(1, 100) <= rd_pct);
            end
        end
        repeat (DEPTH + 3) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/letter_stream_fifo.md
# letter_stream_fifo

Parametrised synchronous FIFO carrying encoded letters from the enigma encoder to a consumer such as the IR transmitter, the display or a future link. It replaces the ad-hoc address counters and single-pulse valid logic with explicit full/empty tracking and valid/ready handshakes on both sides. It also provides an occupancy count, an almost-full flag, a sticky overflow flag and a synchronous flush. It sustains one write and one read per cycle.

## Interface
- WIDTH, 5: data width in bits (one letter code).
- DEPTH, 1000: total capacity in entries, counting the output stage; any value ≥ 4, need not be a power of two.
- AFULL_LEVEL, DEPTH-8: almost_full_out asserts when count_out ≥ AFULL_LEVEL; legal range 1..DEPTH.
- clk_in  in  1  sole clock.
- rst_in  in  1  reset, synchronous and active-high.
- flush_in  in  1  synchronous empty command.
- wr_valid_in  in  1  write request.
- wr_data_in  in  WIDTH  write data.
- wr_ready_out  out  1  space available; high iff count_out < DEPTH.
- rd_valid_out  out  1  rd_data_out holds the oldest entry.
- rd_data_out  out  WIDTH  head data; stable while rd_valid_out && !rd_ready_in.
- rd_ready_in  in  1  consumer pops the head when rd_valid_out is also high.
- count_out  out  $clog2(DEPTH+1)  current occupancy.
- almost_full_out  out  1  count_out ≥ AFULL_LEVEL.
- overflow_out  out  1  sticky: a write was attempted while full.

## Operation
- Write accepted on an edge with wr_valid_in && wr_ready_out. Pop occurs on an edge with rd_valid_out && rd_ready_in.
- wr_ready_out depends only on registered state. It has no combinational path from rd_ready_in, so a write while full is refused even if a pop happens in the same cycle.
- Refused write (wr_valid_in && !wr_ready_out): data discarded, overflow_out set to 1. It stays set until rst_in or flush_in.
- Pointers wrap explicitly at DEPTH-1 → 0; no power-of-two reliance.
- count_out: +1 on accept only, −1 on pop only, unchanged on both or neither; never exceeds DEPTH and never underflows.
- Order is strictly FIFO; no entry is dropped or duplicated across pointer wrap.
- flush_in: count_out, both pointers, rd_valid_out and overflow_out go to 0 on that edge. A write or pop presented in the same cycle is ignored. RAM contents are don't-care.
- rst_in has the same effect as flush_in and takes priority over every other input. Reset mid-transfer loses all data; no partial state survives.
- Reset values: wr_ready_out 1 (combinational from count_out=0), rd_valid_out 0, rd_data_out 0, count_out 0, almost_full_out 0, overflow_out 0.

## Timing
- RAM read latency is 1 cycle. The output stage is a two-entry register (head + prefetch) so the head falls through to the output.
- Empty FIFO, write accepted on edge k: rd_valid_out high after edge k+2; count_out = 1 after edge k.
- Steady state: with count_out ≥ 3 and rd_ready_in held high, one pop per cycle with no bubbles. Simultaneous write+pop at any occupancy leaves count_out unchanged.
- count_out, almost_full_out and wr_ready_out update on the same edge as the handshake that changes occupancy.
- overflow_out rises on the edge of the refused write.
- rd_data_out changes only on a pop, a fall-through into an empty head, flush or reset.

## Structure
- Shared package letter_pkg holds:
  - LETTER_WIDTH = 5
  - LETTER_BUF_DEPTH = 1000
  - the count-width helper function.
- Storage uses the existing sub-module xilinx_true_dual_port_read_first_1_clock_ram with RAM_PERFORMANCE "LOW_LATENCY", port A for writes and port B for reads.
- Pointer/count control and the two-entry output stage live in this module. No other sub-modules.

## Test plan
- Reset, then write 'A'=0 at edge k with rd_ready_in low → rd_valid_out=1 and rd_data_out=0 after edge k+2; count_out=1.
- DEPTH=8: write 0..7 back-to-back, then an extra write of 9 → wr_ready_out=0 after the 8th write, 9 is discarded, overflow_out=1. Draining returns 0..7 in order.
- DEPTH=8: stream 20 values with rd_ready_in=1 and writes every cycle → outputs 0..19 in order with no bubbles after the first valid; count_out constant once steady.
- DEPTH=5, AFULL_LEVEL=3: fill to 3 → almost_full_out rises on the 3rd accept edge; one pop → almost_full_out falls.
- Fill to 4, then assert flush_in together with wr_valid_in and rd_ready_in → after that edge count_out=0, rd_valid_out=0, overflow_out=0. The next write emerges 2 cycles later.
- Assert rst_in mid-stream at count_out=6 → every output takes its reset value on that edge; a subsequent write/read sequence behaves as from power-up.
